// File: rtl/pixel_stream_filter.sv
// pixel_stream_filter: per-frame RGB fetch, luma reduction and point filtering; PIXEL_STREAM_FILTER_STATS_EN adds min/max stats
module pixel_stream_filter #(
  parameter int CH_W       = 8,
  parameter int ADDR_W     = 8,
  parameter int IMG_PIX    = 200,
  parameter int THRESH     = 128,
  parameter int BRIGHT_OFF = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        size,
  input  logic [1:0]        filter,
  input  logic              validData,
  input  logic [3*CH_W-1:0] pixel_in,
  output logic [ADDR_W-1:0] Pixel_address,
  output logic              busy,
  output logic              ValidResult,
  output logic [CH_W-1:0]   pixel_out,
  output logic [ADDR_W-1:0] out_addr,
  output logic              done,
  output logic [CH_W-1:0]   stat_min,
  output logic [CH_W-1:0]   stat_max
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t            state_q, state_d;
  logic [1:0]        size_q, size_d, filter_q, filter_d;
  logic [ADDR_W-1:0] addr_q, addr_d, last_addr, a0_q, a0_d, a1_q, a1_d, a2_q, a2_d;
  logic [3*CH_W-1:0] pix0_q, pix0_d;
  logic [CH_W-1:0]   luma1_q, luma1_d, out2_q, out2_d;
  logic              v0_q, v0_d, v1_q, v1_d, v2_q, v2_d, accept;
  logic [CH_W+1:0]   luma_sum;
  logic [CH_W:0]     bright;
  // control FSM: latches frame config at start, counts accepted pixels, drains the pipeline
  always_comb begin
    last_addr = size_q == 2'd0 ? ADDR_W'(15) :
                size_q == 2'd1 ? ADDR_W'(63) :
                size_q == 2'd2 ? ADDR_W'(255) : ADDR_W'(IMG_PIX - 1);
    accept    = state_q == RUN && validData;
    state_d   = state_q;
    size_d    = size_q;
    filter_d  = filter_q;
    addr_d    = addr_q;
    case (state_q)
      IDLE: if (start) begin
        state_d  = RUN;
        size_d   = size;
        filter_d = filter;
        addr_d   = '0;
      end
      RUN: if (accept) begin
        state_d = addr_q == last_addr ? DRAIN : RUN;
        addr_d  = addr_q == last_addr ? addr_q : addr_q + ADDR_W'(1);
      end
      DRAIN: state_d = !v0_q && !v1_q ? DONE : DRAIN;
      DONE: begin
        state_d = IDLE;
        addr_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // capture, luma and filter stages; the address travels with its pixel
  always_comb begin
    luma_sum = {2'b00, pix0_q[3*CH_W-1:2*CH_W]} + {1'b0, pix0_q[2*CH_W-1:CH_W], 1'b0} +
               {2'b00, pix0_q[CH_W-1:0]};
    bright   = {1'b0, luma1_q} + (CH_W+1)'(BRIGHT_OFF);
    v0_d     = accept;
    pix0_d   = accept ? pixel_in : pix0_q;
    a0_d     = accept ? addr_q : a0_q;
    v1_d     = v0_q;
    luma1_d  = v0_q ? CH_W'(luma_sum >> 2) : luma1_q;
    a1_d     = v0_q ? a0_q : a1_q;
    v2_d     = v1_q;
    out2_d   = !v1_q           ? out2_q :
               filter_q == 2'd0 ? luma1_q :
               filter_q == 2'd1 ? ~luma1_q :
               filter_q == 2'd2 ? (int'(luma1_q) >= THRESH ? '1 : '0) :
               (bright[CH_W] ? '1 : bright[CH_W-1:0]);
    a2_d     = v1_q ? a1_q : a2_q;
  end
  // state and pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      size_q   <= '0;
      filter_q <= '0;
      addr_q   <= '0;
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      pix0_q   <= '0;
      luma1_q  <= '0;
      out2_q   <= '0;
      a0_q     <= '0;
      a1_q     <= '0;
      a2_q     <= '0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      filter_q <= filter_d;
      addr_q   <= addr_d;
      v0_q     <= v0_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      pix0_q   <= pix0_d;
      luma1_q  <= luma1_d;
      out2_q   <= out2_d;
      a0_q     <= a0_d;
      a1_q     <= a1_d;
      a2_q     <= a2_d;
    end
  end
  assign Pixel_address = addr_q;
  assign busy          = state_q == RUN || state_q == DRAIN;
  assign ValidResult   = v2_q;
  assign pixel_out     = out2_q;
  assign out_addr      = a2_q;
  assign done          = state_q == DONE;
`ifdef PIXEL_STREAM_FILTER_STATS_EN
  logic [CH_W-1:0] min_q, min_d, max_q, max_d;
  // running extrema of emitted results, re-armed when a frame starts
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (state_q == IDLE && start) begin
      min_d = '1;
      max_d = '0;
    end else if (v2_q) begin
      min_d = out2_q < min_q ? out2_q : min_q;
      max_d = out2_q > max_q ? out2_q : max_q;
    end
  end
  // statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end
  assign stat_min = min_q;
  assign stat_max = max_q;
`else
  assign stat_min = '0;
  assign stat_max = '0;
`endif
endmodule

// File: tb/tb_pixel_stream_filter.sv
// tb_pixel_stream_filter: randomized scoreboard bench for pixel_stream_filter
module tb_pixel_stream_filter;
  localparam int CH_W = 8, ADDR_W = 8, IMG = 5, TH = 128, OFF = 64;
`ifdef PIXEL_STREAM_FILTER_STATS_EN
  localparam int SMIN_RST = 255;
`else
  localparam int SMIN_RST = 0;
`endif
  logic clk = 0, rst = 1, start = 0, validData = 0;
  logic [1:0] size = 0, filter = 0;
  logic [3*CH_W-1:0] pixel_in = 0;
  logic [ADDR_W-1:0] Pixel_address, out_addr;
  logic busy, ValidResult, done;
  logic [CH_W-1:0] pixel_out, stat_min, stat_max;
  typedef struct {int addr; int val; int c;} exp_t;
  exp_t q[$];
  int dir[$];
  int n_chk = 0, n_fail = 0, cyc = 0, exp_min, exp_max;
  bit done_ok = 0;

  pixel_stream_filter #(.CH_W(CH_W), .ADDR_W(ADDR_W), .IMG_PIX(IMG), .THRESH(TH), .BRIGHT_OFF(OFF)) dut (
    .clk(clk), .rst(rst), .start(start), .size(size), .filter(filter), .validData(validData),
    .pixel_in(pixel_in), .Pixel_address(Pixel_address), .busy(busy), .ValidResult(ValidResult),
    .pixel_out(pixel_out), .out_addr(out_addr), .done(done), .stat_min(stat_min), .stat_max(stat_max));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model(input int p, input int f);
    int l = (((p >> 16) & 255) + 2 * ((p >> 8) & 255) + (p & 255)) / 4;
    if (f == 0) return l;
    if (f == 1) return 255 - l;
    if (f == 2) return l >= TH ? 255 : 0;
    return l + OFF > 255 ? 255 : l + OFF;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ValidResult) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_result: got ValidResult=1 addr %0d expected no pending result", out_addr);
      end else begin
        e = q.pop_front();
        chk("pixel_out", pixel_out, e.val);
        chk("out_addr", out_addr, e.addr);
        chk("result_cycle", cyc, e.c);
      end
    end
    if (done && !done_ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL spurious_done: got done=1 expected 0 (cycle %0d)", cyc);
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"}, Pixel_address, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, ValidResult, 0);
    chk({tag, "_pixel_out"}, pixel_out, 0);
    chk({tag, "_out_addr"}, out_addr, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_stat_min"}, stat_min, SMIN_RST);
    chk({tag, "_stat_max"}, stat_max, 0);
  endtask

  task automatic run_frame(input int sz, input int flt, input int gap_pct, input bit mid_start);
    int n = sz == 0 ? 16 : sz == 1 ? 64 : sz == 2 ? 256 : IMG;
    int cnt = 0, it = 0, p;
    bit v;
    validData = 1;
    pixel_in = $urandom;
    @(posedge clk); #1;
    validData = 0;
    size = 2'(sz);
    filter = 2'(flt);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    size = 2'($urandom);
    filter = 2'($urandom);
    exp_min = 255;
    exp_max = 0;
    while (cnt < n && it < 8 * n + 50) begin
      v = $urandom_range(99) >= gap_pct;
      p = (v && dir.size() > 0) ? dir.pop_front() : int'($urandom_range(24'hffffff));
      pixel_in = 24'(p);
      validData = v;
      start = mid_start && it == 3;
      if (start) filter = 2'(flt + 1);
      chk("pixel_address", Pixel_address, cnt);
      if (v) begin
        q.push_back('{cnt, model(p, flt), cyc + 3});
        if (model(p, flt) < exp_min) exp_min = model(p, flt);
        if (model(p, flt) > exp_max) exp_max = model(p, flt);
      end
      @(posedge clk); #1;
      if (v) cnt++;
      it++;
    end
    validData = 0;
    start = 0;
    if (cnt < n) begin
      n_chk++;
      n_fail++;
      $display("FAIL frame_timeout: got %0d accepts expected %0d", cnt, n);
    end
    validData = 1;
    @(posedge clk); #1;
    validData = 0;
    chk("drain_done", done, 0);
    chk("drain_busy", busy, 1);
    done_ok = 1;
    @(posedge clk); #1;
    chk("last_result_done", done, 0);
    @(posedge clk); #1;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("results_pending", q.size(), 0);
`ifdef PIXEL_STREAM_FILTER_STATS_EN
    chk("stat_min", stat_min, exp_min);
    chk("stat_max", stat_max, exp_max);
`else
    chk("stat_min", stat_min, 0);
    chk("stat_max", stat_max, 0);
`endif
    @(posedge clk); #1;
    done_ok = 0;
    chk("done_single", done, 0);
    chk("idle_addr", Pixel_address, 0);
    q.delete();
  endtask

  task automatic reset_mid_frame();
    int flt = int'($urandom_range(3)), p;
    size = 1;
    filter = 2'(flt);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 5; i++) begin
      p = int'($urandom_range(24'hffffff));
      pixel_in = 24'(p);
      validData = 1;
      q.push_back('{i, model(p, flt), cyc + 3});
      @(posedge clk); #1;
    end
    validData = 0;
    rst = 1;
    @(posedge clk); #1;
    q.delete();
    check_reset_outputs("midrst");
    rst = 0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("midrst_no_done", done, 0);
      chk("midrst_idle_busy", busy, 0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 0;
    dir = '{24'hC86414, 24'h780A35, 24'hD25214, 24'h0A3414, 24'h14520F};
    run_frame(0, 0, 0, 0);
    dir = '{24'hC86414};
    run_frame(0, 1, 0, 0);
    dir = '{24'hC86414, 24'hFFFFFF};
    run_frame(0, 2, 0, 0);
    dir = '{24'h780A35, 24'hFFFFFF};
    run_frame(0, 3, 0, 0);
    dir = '{24'hC86414, 24'h780A35, 24'hD25214, 24'h0A3414, 24'h14520F};
    run_frame(3, 0, 0, 0);
    run_frame(1, int'($urandom_range(3)), 50, 0);
    run_frame(1, 2, 20, 1);
    reset_mid_frame();
    run_frame(1, int'($urandom_range(3)), 0, 0);
    run_frame(2, int'($urandom_range(3)), 10, 0);
    for (int i = 0; i < 6; i++) run_frame(int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(60)), i[0]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
